dot_product_accumulator: RTL and testbench

//  Downstream consumer of the 16x16 signed array multiplier. Accepts a stream of

---
 rtl/dot_product_accumulator.sv | 117 +++++++++++
 tb/tb_dot_product_accumulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// Sums a stream of signed products into a saturating accumulator and presents
// one dot-product result per job over a valid/ready handshake.
module dot_product_accumulator #(
    parameter int unsigned PWIDTH = 32,
    parameter int unsigned AWIDTH = 40,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PWIDTH-1:0] product,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [AWIDTH-1:0] result,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    localparam logic [AWIDTH-1:0] AccMax = {1'b0, {(AWIDTH-1){1'b1}}};
    localparam logic [AWIDTH-1:0] AccMin = {1'b1, {(AWIDTH-1){1'b0}}};

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              ovf_q, ovf_d;

    logic              xfer;
    logic              last_term;
    logic [AWIDTH:0]   prod_ext;
    logic [AWIDTH:0]   sum_wide;

    assign xfer      = prod_valid && (state_q == StAccum);
    assign last_term = (count_q == (len_q - CNT_W'(1)));
    assign prod_ext  = {{(AWIDTH + 1 - PWIDTH){product[PWIDTH-1]}}, product};
    // One guard bit: the two top bits differ exactly when the sum left the AWIDTH range.
    assign sum_wide  = {acc_q[AWIDTH-1], acc_q} + prod_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len != '0) ? StAccum : StHold;
                end
            end
            StAccum: begin
                if (xfer && last_term) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prod_ready   = (state_q == StAccum);
        result_valid = (state_q == StHold);
        busy         = (state_q != StIdle);
        result       = acc_q;
        overflow     = ovf_q;
    end

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if ((state_q == StIdle) && start) begin
            len_d   = len;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (xfer) begin
            count_d = count_q + CNT_W'(1);
            if (sum_wide[AWIDTH] != sum_wide[AWIDTH-1]) begin
                ovf_d = 1'b1;
                acc_d = sum_wide[AWIDTH] ? AccMin : AccMax;
            end else begin
                acc_d = sum_wide[AWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: a default-width instance and a narrow-accumulator
// instance share stimulus so saturation is reachable; results go through a scoreboard.
module tb_dot_product_accumulator;

    localparam int AW  = 40;
    localparam int AWS = 34;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    len;
    logic          prod_valid;
    logic [31:0]   product;
    logic          result_ready;

    logic          prod_ready, result_valid, overflow, busy;
    logic [AW-1:0] result;
    logic          s_prod_ready, s_result_valid, s_overflow, s_busy;
    logic [AWS-1:0] s_result;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [AW-1:0]  r;
        logic           om;
        logic [AWS-1:0] rs;
        logic           os;
    } exp_t;

    exp_t   sb[$];
    longint acc_m, acc_s;
    bit     ov_m, ov_s;

    dot_product_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .product(product),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .overflow(overflow), .busy(busy)
    );

    dot_product_accumulator #(.PWIDTH(32), .AWIDTH(AWS), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(s_prod_ready), .product(product),
        .result_valid(s_result_valid), .result_ready(result_ready),
        .result(s_result), .overflow(s_overflow), .busy(s_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_add(inout longint a, inout bit ov, input longint p, input int aw);
        longint mx, mn, s;
        mx = (longint'(1) <<< (aw - 1)) - 1;
        mn = -(longint'(1) <<< (aw - 1));
        s  = a + p;
        if (s > mx) begin
            a = mx; ov = 1'b1;
        end else if (s < mn) begin
            a = mn; ov = 1'b1;
        end else begin
            a = s;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {prod_ready, s_prod_ready}, 2'b00);
        check({tag, "_rvalid"}, {result_valid, s_result_valid}, 2'b00);
        check({tag, "_busy"}, {busy, s_busy}, 2'b00);
    endtask

    task automatic run_job(input int n, input logic [31:0] prods[$], input int gap,
                           input int hold, input bit stray);
        exp_t e;
        exp_t got;
        if (stray) begin
            prod_valid = 1'b1;
            product    = 32'h7654_3210;
            tick();
            tick();
            check("idle_stray_valid", {prod_ready, busy}, 2'b00);
            prod_valid = 1'b0;
        end
        start = 1'b1;
        len   = n[7:0];
        tick();
        start = 1'b0;
        acc_m = 0; acc_s = 0; ov_m = 0; ov_s = 0;
        check("busy_after_start", {busy, s_busy}, 2'b11);
        check("ready_after_start", prod_ready, (n != 0));
        for (int i = 0; i < n; i++) begin
            repeat (gap) tick();
            if (stray && i == 1) begin
                start = 1'b1;
                len   = 8'd9;
                tick();
                start = 1'b0;
                check("accum_stray_start", {prod_ready, result_valid}, 2'b10);
            end
            prod_valid = 1'b1;
            product    = prods[i];
            model_add(acc_m, ov_m, longint'(signed'(prods[i])), AW);
            model_add(acc_s, ov_s, longint'(signed'(prods[i])), AWS);
            tick();
            prod_valid = 1'b0;
        end
        e.r  = acc_m[AW-1:0];
        e.om = ov_m;
        e.rs = acc_s[AWS-1:0];
        e.os = ov_s;
        sb.push_back(e);
        check("latency_rvalid", {result_valid, s_result_valid}, 2'b11);
        check("hold_ready", {prod_ready, s_prod_ready}, 2'b00);
        if (result_valid && sb.size() > 0) begin
            got = sb.pop_front();
            check("result", result, got.r);
            check("overflow", overflow, got.om);
            check("s_result", s_result, got.rs);
            check("s_overflow", s_overflow, got.os);
        end
        if (stray) begin
            prod_valid = 1'b1;
            product    = 32'h0001_2345;
        end
        repeat (hold) tick();
        if (hold > 0) begin
            check("stall_rvalid", result_valid, 1'b1);
            check("stall_result", {result, s_result}, {e.r, e.rs});
        end
        result_ready = 1'b1;
        if (stray) start = 1'b1;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        prod_valid   = 1'b0;
        check_idle_outputs("exit");
        check("held_result", {result, overflow, s_result, s_overflow}, {e.r, e.om, e.rs, e.os});
        tick();
        check("still_idle", {busy, s_busy}, 2'b00);
    endtask

    initial begin
        logic [31:0] q[$];
        rst_n        = 1'b0;
        start        = 1'b0;
        len          = '0;
        prod_valid   = 1'b0;
        product      = '0;
        result_ready = 1'b0;
        #12;
        check_idle_outputs("reset");
        check("reset_result", {result, overflow, s_result, s_overflow}, '0);
        rst_n = 1'b1;
        tick();
        tick();
        check_idle_outputs("post_reset");

        // Abort a job with reset in the middle of accumulation.
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; product = 32'd5;
        tick();
        prod_valid = 1'b0;
        check("pre_abort_ready", prod_ready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        check("abort_result", {result, overflow, s_result, s_overflow}, '0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        check_idle_outputs("after_abort");

        q = {32'd6, 32'hFFFF_FFEC, 32'd100};
        run_job(3, q, 0, 0, 1'b0);

        q = {32'd1, 32'd2, 32'd3, 32'd4};
        run_job(4, q, 1, 5, 1'b0);

        q = {};
        for (int i = 0; i < 255; i++) q.push_back(32'h7FFF_FFFF);
        run_job(255, q, 0, 0, 1'b0);

        q = {};
        for (int i = 0; i < 255; i++) q.push_back(32'h8000_0000);
        run_job(255, q, 0, 1, 1'b0);

        q = {};
        run_job(0, q, 0, 1, 1'b0);

        q = {32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
        run_job(4, q, 0, 2, 1'b1);

        // Narrow instance clamps positive then negative; overflow must clear on the next start.
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(32'h7FFF_FFFF);
        run_job(5, q, 0, 0, 1'b0);
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(32'h8000_0000);
        run_job(5, q, 2, 0, 1'b0);
        q = {32'd7, 32'hFFFF_FFFE};
        run_job(2, q, 0, 0, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
